// File: rtl/m_stage.sv
`default_nettype none
// ============================================================================
//  Module   : m_stage
//  Purpose  : RV32I memory-access stage. Performs loads/stores over a req/ack
//             data-memory port with misalignment and timeout detection.
//  Revision : 1.0  initial release
// ============================================================================
module m_stage #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_store_data,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic [2:0]  m_funct3,
    input  logic [4:0]  m_rd,
    input  logic        m_reg_write,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        w_valid,
    output logic [31:0] w_pc,
    output logic [31:0] w_result,
    output logic [4:0]  w_rd,
    output logic        w_reg_write,
    output logic        m_misaligned,
    output logic        m_bus_err
);

    localparam int               c_CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0]       c_SZ_B     = 2'd0;
    localparam logic [1:0]       c_SZ_H     = 2'd1;
    localparam logic [1:0]       c_SZ_W     = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_pc;
    logic [31:0]        r_alu;
    logic [4:0]         r_rd;
    logic               r_reg_write;
    logic [2:0]         r_funct3;

    logic        w_is_mem;
    logic        w_accept;
    logic        w_misal;
    logic        w_timeout;
    logic [1:0]  w_size;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    assign m_ready   = (r_state == S_IDLE);
    assign dmem_req  = (r_state == S_ACCESS);
    assign w_is_mem  = m_mem_read | m_mem_write;
    assign w_accept  = m_valid & m_ready;
    assign w_timeout = (r_cnt == c_CNT_LAST);

    // Access size and lane placement from the incoming instruction
    always_comb begin
        w_size  = c_SZ_W;
        w_be    = 4'b1111;
        w_wdata = m_store_data;
        case (m_funct3)
            3'b000, 3'b100: w_size = c_SZ_B;
            3'b001, 3'b101: w_size = c_SZ_H;
            default:        w_size = c_SZ_W;
        endcase
        case (w_size)
            c_SZ_B: begin
                w_be    = 4'b0001 << m_alu_result[1:0];
                w_wdata = {4{m_store_data[7:0]}};
            end
            c_SZ_H: begin
                w_be    = 4'b0011 << {m_alu_result[1], 1'b0};
                w_wdata = {2{m_store_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = m_store_data;
            end
        endcase
    end

    assign w_misal = ((w_size == c_SZ_H) && m_alu_result[0]) ||
                     ((w_size == c_SZ_W) && (m_alu_result[1:0] != 2'b00));

    // Load formatting uses the captured address and funct3
    always_comb begin
        w_ld_byte = dmem_rdata[7:0];
        case (r_alu[1:0])
            2'd0:    w_ld_byte = dmem_rdata[7:0];
            2'd1:    w_ld_byte = dmem_rdata[15:8];
            2'd2:    w_ld_byte = dmem_rdata[23:16];
            default: w_ld_byte = dmem_rdata[31:24];
        endcase
        w_ld_half = r_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && w_is_mem && !w_misal) w_state_next = S_ACCESS;
            S_ACCESS: if (dmem_ack || w_timeout)            w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_pc         <= '0;
            r_alu        <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_funct3     <= '0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            w_valid      <= 1'b0;
            w_pc         <= '0;
            w_result     <= '0;
            w_rd         <= '0;
            w_reg_write  <= 1'b0;
            m_misaligned <= 1'b0;
            m_bus_err    <= 1'b0;
        end else begin
            w_valid      <= 1'b0;
            m_misaligned <= 1'b0;
            m_bus_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!w_is_mem || w_misal) begin
                            w_valid      <= 1'b1;
                            w_pc         <= m_pc;
                            w_result     <= m_alu_result;
                            w_rd         <= m_rd;
                            w_reg_write  <= m_reg_write & ~w_is_mem;
                            m_misaligned <= w_is_mem;
                        end else begin
                            r_cnt       <= '0;
                            r_pc        <= m_pc;
                            r_alu       <= m_alu_result;
                            r_rd        <= m_rd;
                            r_reg_write <= m_reg_write;
                            r_funct3    <= m_funct3;
                            dmem_we     <= m_mem_write;
                            dmem_addr   <= {m_alu_result[31:2], 2'b00};
                            dmem_wdata  <= w_wdata;
                            dmem_be     <= w_be;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ack) begin
                        w_valid     <= 1'b1;
                        w_pc        <= r_pc;
                        w_result    <= dmem_we ? r_alu : w_ld_data;
                        w_rd        <= r_rd;
                        w_reg_write <= r_reg_write;
                    end else if (w_timeout) begin
                        w_valid     <= 1'b1;
                        w_pc        <= r_pc;
                        w_result    <= r_alu;
                        w_rd        <= r_rd;
                        w_reg_write <= 1'b0;
                        m_bus_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m_stage
//  Purpose  : Directed self-checking bench for m_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_m_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        m_valid, m_ready;
    logic [31:0] m_pc, m_alu_result, m_store_data;
    logic        m_mem_read, m_mem_write;
    logic [2:0]  m_funct3;
    logic [4:0]  m_rd;
    logic        m_reg_write;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        w_valid;
    logic [31:0] w_pc, w_result;
    logic [4:0]  w_rd;
    logic        w_reg_write, m_misaligned, m_bus_err;

    int n_cmp = 0;
    int n_err = 0;

    m_stage #(.MEM_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .m_valid(m_valid), .m_ready(m_ready), .m_pc(m_pc),
        .m_alu_result(m_alu_result), .m_store_data(m_store_data),
        .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
        .m_funct3(m_funct3), .m_rd(m_rd), .m_reg_write(m_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .w_valid(w_valid), .w_pc(w_pc),
        .w_result(w_result), .w_rd(w_rd), .w_reg_write(w_reg_write),
        .m_misaligned(m_misaligned), .m_bus_err(m_bus_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction for a single accept edge, then withdraw it
    task automatic issue(input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic rd_op,
                         input logic wr_op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic rw);
        m_valid      = 1'b1;
        m_pc         = pc;
        m_alu_result = addr;
        m_store_data = sdata;
        m_mem_read   = rd_op;
        m_mem_write  = wr_op;
        m_funct3     = f3;
        m_rd         = rd;
        m_reg_write  = rw;
        tick();
        m_valid     = 1'b0;
        m_mem_read  = 1'b0;
        m_mem_write = 1'b0;
    endtask

    // Wait n cycles with no ack, then ack for one cycle; ends in the w_valid cycle
    task automatic ack_after(input int n, input logic [31:0] rdata);
        repeat (n) tick();
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ack   = 1'b0;
    endtask

    initial begin
        int req_cycles;
        reset = 1'b0;
        m_valid = 0; m_pc = 0; m_alu_result = 0; m_store_data = 0;
        m_mem_read = 0; m_mem_write = 0; m_funct3 = 0; m_rd = 0; m_reg_write = 0;
        dmem_ack = 0; dmem_rdata = 0;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", 32'(m_ready), 32'd1);
        chk("rst_wvalid", 32'(w_valid), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_result", w_result, 32'd0);
        reset = 1'b1;
        tick();

        // Three back-to-back ALU ops
        for (int i = 1; i <= 3; i++) begin
            chk("alu_ready", 32'(m_ready), 32'd1);
            m_valid = 1'b1; m_pc = 32'h100 + 32'(4 * i); m_alu_result = 32'(i * 32'h11);
            m_rd = 5'(i); m_reg_write = 1'b1;
            tick();
            chk("alu_wvalid", 32'(w_valid), 32'd1);
            chk("alu_result", w_result, 32'(i * 32'h11));
            chk("alu_pc", w_pc, 32'h100 + 32'(4 * i));
        end
        m_valid = 1'b0;
        tick();
        chk("alu_pulse_end", 32'(w_valid), 32'd0);
        chk("alu_hold", w_result, 32'h33);

        // LB @0x1003 sign-extends byte 3
        issue(32'h200, 32'h1003, 32'h0, 1'b1, 1'b0, 3'b000, 5'd5, 1'b1);
        chk("lb_req", 32'(dmem_req), 32'd1);
        chk("lb_addr", dmem_addr, 32'h1000);
        chk("lb_we", 32'(dmem_we), 32'd0);
        chk("lb_ready", 32'(m_ready), 32'd0);
        ack_after(1, 32'h80FF_FF00);
        chk("lb_wvalid", 32'(w_valid), 32'd1);
        chk("lb_req_drop", 32'(dmem_req), 32'd0);
        chk("lb_result", w_result, 32'hFFFF_FF80);
        chk("lb_rd", 32'(w_rd), 32'd5);
        chk("lb_rw", 32'(w_reg_write), 32'd1);
        tick();
        chk("lb_pulse_end", 32'(w_valid), 32'd0);

        // LBU @0x1001 zero-extends byte 1
        issue(32'h204, 32'h1001, 32'h0, 1'b1, 1'b0, 3'b100, 5'd6, 1'b1);
        ack_after(0, 32'h0000_8000);
        chk("lbu_result", w_result, 32'h0000_0080);

        // LH @0x7002 sign-extends upper half
        issue(32'h208, 32'h7002, 32'h0, 1'b1, 1'b0, 3'b001, 5'd7, 1'b1);
        ack_after(2, 32'h8001_0000);
        chk("lh_result", w_result, 32'hFFFF_8001);

        // SH @0x2002
        issue(32'h300, 32'h2002, 32'h1234_ABCD, 1'b0, 1'b1, 3'b001, 5'd0, 1'b0);
        chk("sh_req", 32'(dmem_req), 32'd1);
        chk("sh_we", 32'(dmem_we), 32'd1);
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", dmem_addr, 32'h2000);
        ack_after(0, 32'h0);
        chk("sh_wvalid", 32'(w_valid), 32'd1);
        chk("sh_rw", 32'(w_reg_write), 32'd0);

        // SB @0x2001
        issue(32'h304, 32'h2001, 32'h0000_00A5, 1'b0, 1'b1, 3'b000, 5'd0, 1'b0);
        chk("sb_be", 32'(dmem_be), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        ack_after(0, 32'h0);

        // LW @0x3001 misaligned
        issue(32'h400, 32'h3001, 32'h0, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1);
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_wvalid", 32'(w_valid), 32'd1);
        chk("mis_flag", 32'(m_misaligned), 32'd1);
        chk("mis_rw", 32'(w_reg_write), 32'd0);
        chk("mis_ready", 32'(m_ready), 32'd1);
        tick();
        chk("mis_pulse_end", 32'(m_misaligned), 32'd0);

        // Ack while idle is ignored
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack", 32'(w_valid), 32'd0);

        // LW with ack withheld times out after 16 request cycles
        issue(32'h500, 32'h4000, 32'h0, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!dmem_req) break;
            req_cycles++;
            tick();
        end
        chk("to_req_cycles", 32'(req_cycles), 32'd16);
        chk("to_wvalid", 32'(w_valid), 32'd1);
        chk("to_bus_err", 32'(m_bus_err), 32'd1);
        chk("to_rw", 32'(w_reg_write), 32'd0);
        tick();
        chk("to_pulse_end", 32'(m_bus_err), 32'd0);

        // Ack in the terminal timeout cycle is a success
        issue(32'h600, 32'h5000, 32'h0, 1'b1, 1'b0, 3'b010, 5'd11, 1'b1);
        ack_after(15, 32'hDEAD_BEEF);
        chk("term_wvalid", 32'(w_valid), 32'd1);
        chk("term_bus_err", 32'(m_bus_err), 32'd0);
        chk("term_result", w_result, 32'hDEAD_BEEF);
        chk("term_rw", 32'(w_reg_write), 32'd1);

        // LHU aborted by asynchronous reset mid-wait
        issue(32'h700, 32'h6002, 32'h0, 1'b1, 1'b0, 3'b101, 5'd12, 1'b1);
        tick();
        tick();
        chk("ar_req_before", 32'(dmem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_req_drop", 32'(dmem_req), 32'd0);
        chk("ar_wvalid", 32'(w_valid), 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ar_no_wvalid", 32'(w_valid), 32'd0);
        end
        chk("ar_ready", 32'(m_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
